// File: rtl/axil_led_pwm_ctrl.sv
// AXI4-Lite LED controller: NUM_LEDS channels, each off / on / blink / PWM.
// Blink steps on a shared prescaler tick; PWM compares against a shared free-running counter.
module axil_led_pwm_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_LEDS           = 8,
    parameter int PWM_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             LED
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int WW = AW - 2;

    logic                 gen_q;
    logic [23:0]          prescale_q;
    logic [1:0]           mode_q     [NUM_LEDS];
    logic [PWM_WIDTH-1:0] duty_q     [NUM_LEDS];
    logic [7:0]           half_q     [NUM_LEDS];
    logic [7:0]           blink_cnt_q[NUM_LEDS];
    logic [NUM_LEDS-1:0]  phase_q, led_q, led_d, wr_ch;
    logic [23:0]          presc_cnt_q;
    logic [PWM_WIDTH-1:0] pwm_cnt_q;
    logic                 tick;

    logic          aw_got_q, w_got_q, awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [WW-1:0] aw_word_q, wr_word;
    logic [31:0]   w_data_q, wr_data, wr_new, rdata_q, wr_word_ext;
    logic [3:0]    w_strb_q, wr_strb;
    logic [1:0]    bresp_q, rresp_q;
    logic          aw_hs, w_hs, ar_hs, wr_en, wr_err;
    logic [32:0]   wr_old, rd_val;

    // Bit 32 of the result flags an unmapped word; data is then 0.
    function automatic logic [32:0] reg_read(input logic [WW-1:0] word);
        logic [32:0] r;
        logic [31:0] w;
        w = {{(32 - WW){1'b0}}, word};
        r = '0;
        r[32] = 1'b1;
        if (w == 32'd0) r = {32'b0, gen_q};
        if (w == 32'd1) begin
            r = '0;
            r[NUM_LEDS-1:0] = led_q;
        end
        if (w == 32'd2) r = {9'b0, prescale_q};
        if (w == 32'd3) r = {1'b0, 32'h1ED0_0000 | 32'(NUM_LEDS)};
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w == 32'(4 + i)) begin
                r = '0;
                r[1:0]             = mode_q[i];
                r[PWM_WIDTH+7:8]   = duty_q[i];
                r[31:24]           = half_q[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        aw_hs       = S_AXI_AWVALID & awready_q;
        w_hs        = S_AXI_WVALID & wready_q;
        ar_hs       = S_AXI_ARVALID & arready_q;
        wr_word     = aw_got_q ? aw_word_q : S_AXI_AWADDR[AW-1:2];
        wr_data     = w_got_q ? w_data_q : S_AXI_WDATA;
        wr_strb     = w_got_q ? w_strb_q : S_AXI_WSTRB;
        wr_word_ext = {{(32 - WW){1'b0}}, wr_word};
        wr_en       = (aw_hs | aw_got_q) & (w_hs | w_got_q);
        wr_old      = reg_read(wr_word);
        wr_err      = wr_old[32];
        rd_val      = reg_read(S_AXI_ARADDR[AW-1:2]);
        for (int b = 0; b < 4; b++) begin
            wr_new[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : wr_old[8*b +: 8];
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            wr_ch[i] = wr_en & ~wr_err & (wr_word_ext == 32'(4 + i));
        end
        tick = gen_q & (presc_cnt_q >= prescale_q);
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            unique case (mode_q[i])
                2'd0:    led_d[i] = 1'b0;
                2'd1:    led_d[i] = 1'b1;
                2'd2:    led_d[i] = phase_q[i];
                default: led_d[i] = pwm_cnt_q < duty_q[i];
            endcase
            led_d[i] = led_d[i] & gen_q;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_word_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            // Each READY is a single-cycle pulse; nothing new is taken while a response is pending.
            awready_q <= S_AXI_AWVALID & ~awready_q & ~aw_got_q & ~bvalid_q & ~wr_en;
            wready_q  <= S_AXI_WVALID & ~wready_q & ~w_got_q & ~bvalid_q & ~wr_en;
            if (wr_en) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
            end else begin
                if (aw_hs) begin
                    aw_got_q  <= 1'b1;
                    aw_word_q <= S_AXI_AWADDR[AW-1:2];
                end
                if (w_hs) begin
                    w_got_q  <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (bvalid_q & S_AXI_BREADY) bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q  <= 1'b1;
                arready_q <= 1'b0;
                rdata_q   <= rd_val[31:0];
                rresp_q   <= rd_val[32] ? 2'b10 : 2'b00;
            end else if (rvalid_q & S_AXI_RREADY) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end else begin
                arready_q <= ~rvalid_q;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gen_q      <= 1'b0;
            prescale_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= '0;
                duty_q[i] <= '0;
                half_q[i] <= '0;
            end
        end else if (wr_en & ~wr_err) begin
            if (wr_word_ext == 32'd0) gen_q <= wr_new[0];
            if (wr_word_ext == 32'd2) prescale_q <= wr_new[23:0];
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_ch[i]) begin
                    mode_q[i] <= wr_new[1:0];
                    duty_q[i] <= wr_new[PWM_WIDTH+7:8];
                    half_q[i] <= wr_new[31:24];
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            phase_q     <= '0;
            led_q       <= '0;
            for (int i = 0; i < NUM_LEDS; i++) blink_cnt_q[i] <= '0;
        end else begin
            if (!gen_q) begin
                presc_cnt_q <= '0;
                pwm_cnt_q   <= '0;
            end else begin
                presc_cnt_q <= tick ? 24'd0 : presc_cnt_q + 24'd1;
                pwm_cnt_q   <= pwm_cnt_q + PWM_WIDTH'(1);
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                // A write to the channel restarts its blink cycle, even on a tick.
                if (!gen_q || wr_ch[i]) begin
                    blink_cnt_q[i] <= '0;
                    phase_q[i]     <= 1'b0;
                end else if (tick && mode_q[i] == 2'd2) begin
                    if (blink_cnt_q[i] >= ((half_q[i] == 8'd0) ? 8'd0 : half_q[i] - 8'd1)) begin
                        blink_cnt_q[i] <= '0;
                        phase_q[i]     <= ~phase_q[i];
                    end else begin
                        blink_cnt_q[i] <= blink_cnt_q[i] + 8'd1;
                    end
                end
            end
            led_q <= led_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign LED           = led_q;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
